relu_array: RTL and testbench
=============================

// Module: relu_array
// PURPOSE
//  Multi-channel, parametrised activation unit; successor to the single-channel 8-bit ReLU.
//  Applies one of four per-beat-selectable activations to CH signed lanes in parallel.
//  Uses a 2-stage valid/ready pipeline instead of the external out_en strobe.
//  Sits between the MAC/accumulator output and the next layer's buffer; counts zeroed negatives.
// PARAMETERS
//  DATA_W   8    lane width, signed two's complement
//  CH       4    number of parallel lanes
//  CNT_W    16   width of negative-element counter
//  SHIFT_W  $clog2(DATA_W)  width of leak shift field (derived, do not override)
// PORTS
//  clk             in   1             rising-edge clock
//  rst_n           in   1             async active-low reset
//  cfg_mode        in   2             0 ReLU, 1 leaky ReLU, 2 clipped ReLU, 3 bypass
//  cfg_leak_shift  in   SHIFT_W       leaky mode: negative x -> x >>> cfg_leak_shift
//  cfg_clip        in   DATA_W-1      clipped mode upper bound, unsigned non-negative
//  in_valid        in   1             input beat valid
//  in_ready        out  1             unit can accept a beat this cycle
//  in_data         in   CH*DATA_W     lane i = in_data[i*DATA_W +: DATA_W]
//  out_valid       out  1             output beat valid
//  out_ready       in   1             downstream accepts a beat
//  out_data        out  CH*DATA_W     activated lanes, same packing as in_data
//  clr_cnt         in   1             synchronous clear of neg_cnt
//  neg_cnt         out  CNT_W         saturating count of negative lanes accepted
// BEHAVIOUR
//  - Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, neg_cnt=0.
//    in_ready is 1 after reset. Reset mid-stream drops all in-flight beats.
//  - Handshake: transfer occurs when valid && ready on the same rising edge.
//    out_valid/out_data hold stable while out_valid && !out_ready.
//  - Stage enables:
//    s2_ld = !s2_valid || out_ready;  s1_ld = !s1_valid || s2_ld;  in_ready = s1_ld.
//    in_ready is combinational from out_ready; no combinational path from in_valid to out.
//  - Stage 1 registers in_data together with cfg_mode, cfg_leak_shift and cfg_clip on accept.
//    Config changes therefore affect only beats accepted after the change.
//  - Stage 2 computes the activation per lane from the stage-1 snapshot and registers it.
//  - Latency is exactly 2 cycles, accept edge to out_valid, with out_ready=1.
//    Throughput is 1 beat/cycle. Full pipeline plus stall holds 2 beats; in_ready=0 then.
//  - Arithmetic per lane x (signed DATA_W):
//    mode0: x<0 ? 0 : x
//    mode1: x<0 ? x>>>cfg_leak_shift (arithmetic, floors) : x; shift 0 = bypass
//    mode2: x<0 ? 0 : (x > cfg_clip ? cfg_clip : x), with cfg_clip zero-extended
//    mode3: x unchanged
//    Output width is DATA_W; no overflow is possible.
//  - neg_cnt: on each input accept, add the number of lanes with MSB=1, in any mode.
//    Saturates at 2^CNT_W-1 and never wraps.
//    clr_cnt has priority: if it is asserted in the same cycle as an accept, neg_cnt becomes 0.
//  - Idle (in_valid=0): pipeline drains normally; out_data holds its last value when out_valid=0.
// TESTING
//  1 rst_n low 100ns with in_valid=1 -> out_valid=0, neg_cnt=0, no accepts; in_ready=1 after release.
//  2 CH=4, mode0, in_data=32'h9A2E_7F80, out_ready=1
//    -> 2 cycles later out_data=32'h002E_7F00, neg_cnt=2.
//  3 mode1, shift=2, lane=8'h9A (-102) -> 8'hE6 (-26); lane 8'h80 -> 8'hE0; 8'h2E -> 8'h2E.
//  4 mode2, cfg_clip=7'h20, lanes 2E/10/9A/7F -> 20/10/00/20; change cfg mid-stream
//    -> only later beats are affected.
//  5 Back-pressure: stream 5 beats, hold out_ready=0 for 4 cycles
//    -> in_ready=0 after 2 accepts, no loss or duplication, order preserved.
//  6 Counter: CNT_W=4, 20 all-negative beats -> neg_cnt=15, held;
//    clr_cnt with simultaneous accept -> 0.

Source files
------------

// File: rtl/relu_array.sv
// relu_array: CH-lane signed activation unit (ReLU / leaky / clipped / bypass) with a
// 2-stage valid/ready pipeline and a saturating count of negative input lanes.
`default_nettype none

module relu_array #(
   parameter int DATA_W  = 8,
   parameter int CH      = 4,
   parameter int CNT_W   = 16,
   parameter int SHIFT_W = $clog2(DATA_W)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           cfg_mode,
   input  logic [SHIFT_W-1:0]   cfg_leak_shift,
   input  logic [DATA_W-2:0]    cfg_clip,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH*DATA_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH*DATA_W-1:0] out_data,
   input  logic                 clr_cnt,
   output logic [CNT_W-1:0]     neg_cnt
);

   localparam logic [1:0] MODE_RELU  = 2'd0;
   localparam logic [1:0] MODE_LEAKY = 2'd1;
   localparam logic [1:0] MODE_CLIP  = 2'd2;

   logic                 s1_valid;
   logic                 s2_valid;
   logic                 s1_ld;
   logic                 s2_ld;
   logic [CH*DATA_W-1:0] s1_data;
   logic [1:0]           s1_mode;
   logic [SHIFT_W-1:0]   s1_shift;
   logic [DATA_W-2:0]    s1_clip;
   logic [CH*DATA_W-1:0] act_data;
   logic [CNT_W:0]       neg_lanes;
   logic [CNT_W:0]       neg_sum;

   assign s2_ld     = !s2_valid || out_ready;
   assign s1_ld     = !s1_valid || s2_ld;
   assign in_ready  = s1_ld;
   assign out_valid = s2_valid;

   // Config is snapshotted with the beat so mid-stream changes only touch later beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_mode  <= '0;
         s1_shift <= '0;
         s1_clip  <= '0;
      end else if (s1_ld) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data  <= in_data;
            s1_mode  <= cfg_mode;
            s1_shift <= cfg_leak_shift;
            s1_clip  <= cfg_clip;
         end
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_lane
      logic signed [DATA_W-1:0] x;
      logic signed [DATA_W-1:0] y;
      logic signed [DATA_W-1:0] clip_ext;

      assign x        = s1_data[i*DATA_W +: DATA_W];
      assign clip_ext = {1'b0, s1_clip};

      always_comb begin
         y = x;
         case (s1_mode)
            MODE_RELU: begin
               if (x[DATA_W-1]) y = '0;
            end
            MODE_LEAKY: begin
               if (x[DATA_W-1]) y = x >>> s1_shift;
            end
            MODE_CLIP: begin
               if (x[DATA_W-1])      y = '0;
               else if (x > clip_ext) y = clip_ext;
            end
            default: y = x;
         endcase
      end

      assign act_data[i*DATA_W +: DATA_W] = y;
   end

   // out_data only updates on a real beat so it holds its last value while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_data <= '0;
      end else if (s2_ld) begin
         s2_valid <= s1_valid;
         if (s1_valid) out_data <= act_data;
      end
   end

   always_comb begin
      neg_lanes = '0;
      for (int i = 0; i < CH; i++) begin
         neg_lanes = neg_lanes + (CNT_W+1)'(in_data[i*DATA_W + DATA_W - 1]);
      end
      neg_sum = {1'b0, neg_cnt} + neg_lanes;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_cnt <= '0;
      end else if (clr_cnt) begin
         neg_cnt <= '0;
      end else if (in_valid && in_ready) begin
         neg_cnt <= neg_sum[CNT_W] ? '1 : neg_sum[CNT_W-1:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_relu_array.sv
// tb_relu_array: directed vector table plus hand-written back-pressure, config and counter sequences.
`default_nettype none

module tb_relu_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  cfg_mode;
   logic [2:0]  cfg_leak_shift;
   logic [6:0]  cfg_clip;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        clr_cnt;
   logic [3:0]  neg_cnt;

   int checks = 0;
   int errors = 0;

   relu_array #(.DATA_W(8), .CH(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_mode(cfg_mode), .cfg_leak_shift(cfg_leak_shift), .cfg_clip(cfg_clip),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .clr_cnt(clr_cnt), .neg_cnt(neg_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [2:0]  shift;
      logic [6:0]  clip;
      logic [31:0] din;
      logic [31:0] dout;
      logic [3:0]  neg;
   } vec_t;

   vec_t        vecs[10];
   logic [31:0] bp_in[5];
   logic [31:0] bp_exp[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent;
      int got;
      logic fire_in;
      logic fire_out;

      vecs[0] = '{2'd0, 3'd0, 7'h00, 32'h9A2E_7F80, 32'h002E_7F00, 4'd2};
      vecs[1] = '{2'd1, 3'd2, 7'h00, 32'h9A2E_7F80, 32'hE62E_7FE0, 4'd2};
      vecs[2] = '{2'd2, 3'd0, 7'h20, 32'h2E10_9A7F, 32'h2010_0020, 4'd1};
      vecs[3] = '{2'd3, 3'd5, 7'h05, 32'h9A2E_7F80, 32'h9A2E_7F80, 4'd2};
      vecs[4] = '{2'd1, 3'd0, 7'h00, 32'hFF01_7F80, 32'hFF01_7F80, 4'd2};
      vecs[5] = '{2'd1, 3'd7, 7'h00, 32'hFF81_C001, 32'hFFFF_FF01, 4'd3};
      vecs[6] = '{2'd2, 3'd0, 7'h7F, 32'h7F80_0001, 32'h7F00_0001, 4'd1};
      vecs[7] = '{2'd2, 3'd0, 7'h00, 32'h017F_00FF, 32'h0000_0000, 4'd1};
      vecs[8] = '{2'd0, 3'd3, 7'h10, 32'h0000_0000, 32'h0000_0000, 4'd0};
      vecs[9] = '{2'd2, 3'd0, 7'h10, 32'h1011_0FF0, 32'h1010_0F00, 4'd1};

      bp_in[0] = 32'h1122_3344;  bp_exp[0] = 32'h1122_3344;
      bp_in[1] = 32'h8510_2030;  bp_exp[1] = 32'h0010_2030;
      bp_in[2] = 32'h01FF_02FE;  bp_exp[2] = 32'h0100_0200;
      bp_in[3] = 32'h7F7E_8081;  bp_exp[3] = 32'h7F7E_0000;
      bp_in[4] = 32'h5566_7788;  bp_exp[4] = 32'h5566_7700;

      // Reset held with a valid beat presented
      rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h8080_8080; out_ready = 1'b1;
      clr_cnt = 1'b0; cfg_mode = 2'd0; cfg_leak_shift = 3'd0; cfg_clip = 7'h00;
      #100;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_neg_cnt", neg_cnt, 4'd0);
      chk("rst_out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      tick();
      chk("rst_no_accept", neg_cnt, 4'd0);

      for (int v = 0; v < 10; v++) begin
         clr_cnt = 1'b1;
         tick();
         clr_cnt = 1'b0;
         cfg_mode = vecs[v].mode; cfg_leak_shift = vecs[v].shift; cfg_clip = vecs[v].clip;
         in_data = vecs[v].din; in_valid = 1'b1;
         #1;
         chk($sformatf("vec%0d_in_ready", v), in_ready, 1'b1);
         tick();
         in_valid = 1'b0;
         cfg_mode = ~vecs[v].mode; cfg_leak_shift = ~vecs[v].shift; cfg_clip = ~vecs[v].clip;
         in_data = 32'hFFFF_FFFF;
         chk($sformatf("vec%0d_early", v), out_valid, 1'b0);
         tick();
         chk($sformatf("vec%0d_valid", v), out_valid, 1'b1);
         chk($sformatf("vec%0d_data", v), out_data, vecs[v].dout);
         chk($sformatf("vec%0d_neg", v), neg_cnt, vecs[v].neg);
      end
      tick();
      tick();
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_hold", out_data, 32'h1010_0F00);

      // Config change between back-to-back beats
      cfg_mode = 2'd2; cfg_clip = 7'h20; in_data = 32'h2E2E_2E2E; in_valid = 1'b1;
      tick();
      cfg_clip = 7'h10;
      tick();
      in_valid = 1'b0;
      chk("cfg_beat_a", out_data, 32'h2020_2020);
      tick();
      chk("cfg_beat_b_valid", out_valid, 1'b1);
      chk("cfg_beat_b", out_data, 32'h1010_1010);
      tick();

      // Back-pressure: 5 beats, out_ready low for the first 4 cycles
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      cfg_mode = 2'd0;
      sent = 0; got = 0;
      for (int c = 0; c < 30 && got < 5; c++) begin
         out_ready = (c >= 4);
         in_valid  = (sent < 5);
         in_data   = bp_in[(sent < 5) ? sent : 0];
         #1;
         if (c == 2) chk("bp_in_ready_full", in_ready, 1'b0);
         if (c == 3) begin
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", out_data, bp_exp[0]);
         end
         fire_in  = in_valid && in_ready;
         fire_out = out_valid && out_ready;
         if (fire_out) begin
            chk($sformatf("bp_order%0d", got), out_data, bp_exp[got]);
            got++;
         end
         tick();
         if (fire_in) sent++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_received", got, 5);
      #1;
      chk("bp_no_dup", out_valid, 1'b0);
      chk("bp_neg_cnt", neg_cnt, 4'd6);

      // Counter saturation and clear priority
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      in_data = 32'h8080_8080; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 2) chk("cnt_12", neg_cnt, 4'd12);
         if (i == 3) chk("cnt_sat", neg_cnt, 4'd15);
      end
      chk("cnt_after20", neg_cnt, 4'd15);
      in_valid = 1'b0;
      tick();
      tick();
      chk("cnt_held", neg_cnt, 4'd15);
      in_valid = 1'b1; clr_cnt = 1'b1;
      tick();
      chk("cnt_clr_prio", neg_cnt, 4'd0);
      clr_cnt = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("cnt_restart", neg_cnt, 4'd4);
      tick();
      tick();

      // Reset mid-stream drops in-flight beats
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", out_valid, 1'b0);
      chk("rst_mid_cnt", neg_cnt, 4'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("rst_mid_drained", out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
